// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - sizing and pointer helpers shared by the sync_fifo files
//
// Purpose: width helpers and the pointer wrap rule, so that the interface,
// the storage and the control logic all size and advance pointers the same way.
// No ports (package).

package sync_fifo_pkg;

  // Bits needed to hold an occupancy of 0..depth inclusive.
  function automatic int lvl_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Bits needed to address depth entries; never less than 1 so that an
  // illegal depth still elaborates far enough to report its own error.
  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Explicit compare against the last index lets DEPTH be any integer,
  // not only a power of two.
  function automatic int ptr_next(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// rtl/sync_fifo_if.sv - write/read/status bundle between a producer-consumer and sync_fifo
//
// Purpose: groups the FIFO's data, handshake and status signals.
// Modports:
//   master - the user side: drives i_wdata, i_wen, i_ren (and i_wm_clr),
//            observes all o_* signals.
//   slave  - the FIFO side: the mirror image.
// Signals:
//   i_wdata/i_wen            write word and write request
//   i_ren                    read request (pop in FWFT mode)
//   o_rdata                  read word
//   o_full/o_almost_full     occupancy flags, write side
//   o_empty/o_almost_empty   occupancy flags, read side
//   o_level                  occupancy 0..DEPTH
//   o_overflow/o_underflow   one-cycle rejected-request pulses
// Optional (macro SYNC_FIFO_WATERMARK_EN):
//   i_wm_clr                 clear high-water mark to current level
//   o_max_level              high-water mark of o_level since reset/clear

interface sync_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5
);
  import sync_fifo_pkg::*;

  localparam int LVL_W = lvl_width(DEPTH);

  logic [WIDTH-1:0] i_wdata;
  logic             i_wen;
  logic             o_full;
  logic             o_almost_full;
  logic [WIDTH-1:0] o_rdata;
  logic             i_ren;
  logic             o_empty;
  logic             o_almost_empty;
  logic [LVL_W-1:0] o_level;
  logic             o_overflow;
  logic             o_underflow;

`ifdef SYNC_FIFO_WATERMARK_EN
  logic             i_wm_clr;
  logic [LVL_W-1:0] o_max_level;

  modport master (
    output i_wdata, i_wen, i_ren, i_wm_clr,
    input  o_full, o_almost_full, o_rdata, o_empty, o_almost_empty,
           o_level, o_overflow, o_underflow, o_max_level
  );

  modport slave (
    input  i_wdata, i_wen, i_ren, i_wm_clr,
    output o_full, o_almost_full, o_rdata, o_empty, o_almost_empty,
           o_level, o_overflow, o_underflow, o_max_level
  );
`else
  modport master (
    output i_wdata, i_wen, i_ren,
    input  o_full, o_almost_full, o_rdata, o_empty, o_almost_empty,
           o_level, o_overflow, o_underflow
  );

  modport slave (
    input  i_wdata, i_wen, i_ren,
    output o_full, o_almost_full, o_rdata, o_empty, o_almost_empty,
           o_level, o_overflow, o_underflow
  );
`endif

endinterface

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - fifo_mem: DEPTH x WIDTH storage, one write port, async read port
//
// Purpose: plain register-file storage for sync_fifo. Contents are not reset;
// the controller's level register decides which entries are meaningful.
// Ports:
//   i_clk    clock, write on rising edge
//   i_we     write enable
//   i_waddr  write index 0..DEPTH-1
//   i_wdata  write word
//   i_raddr  read index 0..DEPTH-1
//   o_rdata  word at i_raddr (combinational)

module fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5
) (
  input  logic                         i_clk,
  input  logic                         i_we,
  input  logic [ptr_width(DEPTH)-1:0]  i_waddr,
  input  logic [WIDTH-1:0]             i_wdata,
  input  logic [ptr_width(DEPTH)-1:0]  i_raddr,
  output logic [WIDTH-1:0]             o_rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO, any depth, FWFT or registered read, level and threshold flags
//
// Purpose: intra-domain buffer between pipeline stages. Owns the write/read
// pointers, the level register, all flags and the read data register;
// storage lives in fifo_mem.
// Ports:
//   i_clk    clock, all state on the rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      sync_fifo_if.slave: i_wdata/i_wen, i_ren, o_rdata, o_full,
//            o_almost_full, o_empty, o_almost_empty, o_level, o_overflow,
//            o_underflow (plus i_wm_clr/o_max_level with the macro below)
// Optional feature: define SYNC_FIFO_WATERMARK_EN to add the high-water mark.

module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 5,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  sync_fifo_if.slave  bus
);

  localparam int LVL_W = lvl_width(DEPTH);
  localparam int PTR_W = ptr_width(DEPTH);

  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             full, empty, wa, ra;
  logic [WIDTH-1:0] mem_rdata;

  // Flags decode the level register alone, so they never glitch on the
  // request inputs and carry no extra latency.
  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);

  // A full FIFO rejects writes even when a read happens in the same cycle,
  // and an empty one rejects reads even alongside a write.
  assign wa = bus.i_wen & ~full;
  assign ra = bus.i_ren & ~empty;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    level_d     = level_q;
    overflow_d  = bus.i_wen & full;
    underflow_d = bus.i_ren & empty;
    if (wa) begin
      wptr_d = PTR_W'(ptr_next(int'(wptr_q), DEPTH));
    end
    if (ra) begin
      rptr_d = PTR_W'(ptr_next(int'(rptr_q), DEPTH));
    end
    if (wa && !ra) begin
      level_d = level_q + LVL_W'(1);
    end else if (!wa && ra) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (wa),
    .i_waddr (wptr_q),
    .i_wdata (bus.i_wdata),
    .i_raddr (rptr_q),
    .o_rdata (mem_rdata)
  );

  if (FWFT != 0) begin : g_fwft
    // Head word shows through directly. Masking while empty keeps the
    // output at zero after reset instead of exposing unreset storage.
    assign bus.o_rdata = empty ? '0 : mem_rdata;
  end else begin : g_reg_read
    logic [WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
      rdata_d = rdata_q;
      if (ra) begin
        rdata_d = mem_rdata;
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        rdata_q <= '0;
      end else begin
        rdata_q <= rdata_d;
      end
    end

    assign bus.o_rdata = rdata_q;
  end

`ifdef SYNC_FIFO_WATERMARK_EN
  logic [LVL_W-1:0] max_level_q, max_level_d;

  // Clear wins over tracking; clearing lands on the pre-edge level.
  always_comb begin
    max_level_d = max_level_q;
    if (bus.i_wm_clr) begin
      max_level_d = level_q;
    end else if (level_d > max_level_q) begin
      max_level_d = level_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      max_level_q <= '0;
    end else begin
      max_level_q <= max_level_d;
    end
  end

  assign bus.o_max_level = max_level_q;
`endif

  assign bus.o_full         = full;
  assign bus.o_empty        = empty;
  assign bus.o_almost_full  = (level_q >= LVL_W'(AF_THRESH));
  assign bus.o_almost_empty = (level_q <= LVL_W'(AE_THRESH));
  assign bus.o_level        = level_q;
  assign bus.o_overflow     = overflow_q;
  assign bus.o_underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - directed self-checking bench for sync_fifo (registered, FWFT, thresholds)
//
// Three instances, all DEPTH=5, WIDTH=8:
//   u0 FWFT=0 default thresholds, u1 FWFT=1, u2 FWFT=0 AF_THRESH=3 AE_THRESH=1.
// With SYNC_FIFO_WATERMARK_EN defined the high-water mark of u2 is exercised.

module tb_sync_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  sync_fifo_if #(.WIDTH(8), .DEPTH(5)) b0 ();
  sync_fifo_if #(.WIDTH(8), .DEPTH(5)) b1 ();
  sync_fifo_if #(.WIDTH(8), .DEPTH(5)) b2 ();

  sync_fifo #(.WIDTH(8), .DEPTH(5), .FWFT(0)) u0 (.i_clk(clk), .i_rst_n(rst_n), .bus(b0));
  sync_fifo #(.WIDTH(8), .DEPTH(5), .FWFT(1)) u1 (.i_clk(clk), .i_rst_n(rst_n), .bus(b1));
  sync_fifo #(.WIDTH(8), .DEPTH(5), .FWFT(0), .AF_THRESH(3), .AE_THRESH(1))
    u2 (.i_clk(clk), .i_rst_n(rst_n), .bus(b2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ae_up[4];
    int af_up[4];
    int ae_dn[4];
    int af_dn[4];
    ae_up = '{1, 0, 0, 0};
    af_up = '{0, 0, 1, 1};
    ae_dn = '{0, 0, 1, 1};
    af_dn = '{1, 0, 0, 0};

    b0.i_wen = 1'b0; b0.i_ren = 1'b0; b0.i_wdata = '0;
    b1.i_wen = 1'b0; b1.i_ren = 1'b0; b1.i_wdata = '0;
    b2.i_wen = 1'b0; b2.i_ren = 1'b0; b2.i_wdata = '0;
`ifdef SYNC_FIFO_WATERMARK_EN
    b0.i_wm_clr = 1'b0; b1.i_wm_clr = 1'b0; b2.i_wm_clr = 1'b0;
`endif

    // Reset state
    #2 rst_n = 1'b0;
    step();
    step();
    check("rst_empty", 32'(b0.o_empty), 1);
    check("rst_full", 32'(b0.o_full), 0);
    check("rst_ae", 32'(b0.o_almost_empty), 1);
    check("rst_af", 32'(b0.o_almost_full), 0);
    check("rst_level", 32'(b0.o_level), 0);
    check("rst_rdata", 32'(b0.o_rdata), 0);
    check("rst_ovf", 32'(b0.o_overflow), 0);
    check("rst_unf", 32'(b0.o_underflow), 0);
    check("rst_fwft_rdata", 32'(b1.o_rdata), 0);
    check("rst_fwft_empty", 32'(b1.o_empty), 1);
    rst_n = 1'b1;
    step();

    // Fill u0 with 0x11..0x55
    for (int i = 0; i < 5; i++) begin
      b0.i_wen = 1'b1;
      b0.i_wdata = 8'(17 * (i + 1));
      step();
      check("fill_level", 32'(b0.o_level), 32'(i + 1));
    end
    b0.i_wen = 1'b0;
    check("fill_full", 32'(b0.o_full), 1);
    check("fill_af", 32'(b0.o_almost_full), 1);
    check("fill_empty", 32'(b0.o_empty), 0);

    // Write while full
    b0.i_wen = 1'b1;
    b0.i_wdata = 8'h66;
    step();
    b0.i_wen = 1'b0;
    check("ovf_pulse", 32'(b0.o_overflow), 1);
    check("ovf_level", 32'(b0.o_level), 5);
    step();
    check("ovf_clear", 32'(b0.o_overflow), 0);

    // Drain: each word appears one edge after its read request
    b0.i_ren = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("drain_rdata", 32'(b0.o_rdata), 32'(17 * (k + 1)));
    end
    b0.i_ren = 1'b0;
    check("drain_empty", 32'(b0.o_empty), 1);
    check("drain_level", 32'(b0.o_level), 0);

    // Read while empty
    b0.i_ren = 1'b1;
    step();
    b0.i_ren = 1'b0;
    check("unf_pulse", 32'(b0.o_underflow), 1);
    check("unf_level", 32'(b0.o_level), 0);
    check("unf_rdata_hold", 32'(b0.o_rdata), 'h55);
    step();
    check("unf_clear", 32'(b0.o_underflow), 0);

    // Wrap: prime 2 words, then 20 simultaneous write/read pairs
    b0.i_wen = 1'b1;
    b0.i_wdata = 8'h20;
    step();
    b0.i_wdata = 8'h21;
    step();
    b0.i_ren = 1'b1;
    for (int j = 0; j < 20; j++) begin
      b0.i_wdata = 8'(32'h22 + j);
      step();
      check("wrap_rdata", 32'(b0.o_rdata), 32'(32'h20 + j));
      check("wrap_level", 32'(b0.o_level), 2);
    end
    b0.i_wen = 1'b0;
    step();
    check("wrap_tail0", 32'(b0.o_rdata), 'h34);
    step();
    check("wrap_tail1", 32'(b0.o_rdata), 'h35);
    b0.i_ren = 1'b0;
    check("wrap_empty", 32'(b0.o_empty), 1);

    // FWFT: single word falls through with no read request
    b1.i_wen = 1'b1;
    b1.i_wdata = 8'hA5;
    step();
    b1.i_wen = 1'b0;
    check("fwft_empty", 32'(b1.o_empty), 0);
    check("fwft_rdata", 32'(b1.o_rdata), 'hA5);
    check("fwft_level", 32'(b1.o_level), 1);
    b1.i_ren = 1'b1;
    step();
    check("fwft_pop_empty", 32'(b1.o_empty), 1);
    step();
    b1.i_ren = 1'b0;
    check("fwft_unf", 32'(b1.o_underflow), 1);
    check("fwft_unf_level", 32'(b1.o_level), 0);
    step();
    check("fwft_unf_clear", 32'(b1.o_underflow), 0);

    // FWFT: next word shows right after the pop edge
    b1.i_wen = 1'b1;
    b1.i_wdata = 8'hB1;
    step();
    b1.i_wdata = 8'hB2;
    step();
    b1.i_wen = 1'b0;
    check("fwft_head", 32'(b1.o_rdata), 'hB1);
    b1.i_ren = 1'b1;
    step();
    check("fwft_next", 32'(b1.o_rdata), 'hB2);
    check("fwft_next_level", 32'(b1.o_level), 1);
    step();
    b1.i_ren = 1'b0;
    check("fwft_final_empty", 32'(b1.o_empty), 1);

    // Thresholds AF=3, AE=1 on u2
    check("thr_ae0", 32'(b2.o_almost_empty), 1);
    check("thr_af0", 32'(b2.o_almost_full), 0);
    for (int i = 0; i < 4; i++) begin
      b2.i_wen = 1'b1;
      b2.i_wdata = 8'(32'h40 + i);
      step();
      b2.i_wen = 1'b0;
      check("thr_up_ae", 32'(b2.o_almost_empty), 32'(ae_up[i]));
      check("thr_up_af", 32'(b2.o_almost_full), 32'(af_up[i]));
    end
    for (int k = 0; k < 4; k++) begin
      b2.i_ren = 1'b1;
      step();
      b2.i_ren = 1'b0;
      check("thr_dn_ae", 32'(b2.o_almost_empty), 32'(ae_dn[k]));
      check("thr_dn_af", 32'(b2.o_almost_full), 32'(af_dn[k]));
      check("thr_dn_rdata", 32'(b2.o_rdata), 32'(32'h40 + k));
`ifdef SYNC_FIFO_WATERMARK_EN
      if (k == 2) begin
        check("wm_peak", 32'(b2.o_max_level), 4);
        b2.i_wm_clr = 1'b1;
        step();
        b2.i_wm_clr = 1'b0;
        check("wm_clr", 32'(b2.o_max_level), 1);
      end
`endif
    end

    // Asynchronous reset between edges with 3 words queued in u0
    b0.i_wen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b0.i_wdata = 8'(32'h31 + i);
      step();
    end
    b0.i_wen = 1'b0;
    check("arst_pre_level", 32'(b0.o_level), 3);
    #3 rst_n = 1'b0;
    #1;
    check("arst_empty", 32'(b0.o_empty), 1);
    check("arst_level", 32'(b0.o_level), 0);
    check("arst_rdata", 32'(b0.o_rdata), 0);
    check("arst_full", 32'(b0.o_full), 0);
    step();
    rst_n = 1'b1;
    step();
    check("arst_after_empty", 32'(b0.o_empty), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
